// File: rtl/seg_scan_engine.sv
// rtl/seg_scan_engine.sv - multiplexed seven-segment scan engine with frame-shadowed data
module seg_scan_engine #(
    parameter int DIGITS       = 8,
    parameter int CNT_DIV      = 50000,
    parameter int BLANK_CYC    = 4,
    parameter int BLINK_FRAMES = 64
) (
    input  logic                  i_clk,
    input  logic                  r_rst_n,
    input  logic [4*DIGITS-1:0]   i_data,
    input  logic [DIGITS-1:0]     i_dp,
    input  logic [DIGITS-1:0]     i_blink,
    input  logic                  i_lz_en,
    input  logic [3:0]            i_bright,
    input  logic                  i_load,
    output logic [DIGITS-1:0]     o_seg_control,
    output logic [7:0]            o_seg_display,
    output logic                  o_frame_done
);

    localparam int PW = $clog2(CNT_DIV);
    localparam int SW = $clog2(DIGITS);
    localparam int FW = $clog2(2 * BLINK_FRAMES);

    localparam logic [PW-1:0] PRE_LAST  = PW'(CNT_DIV - 1);
    localparam logic [SW-1:0] SLOT_LAST = SW'(DIGITS - 1);
    localparam logic [FW-1:0] FRM_LAST  = FW'(2 * BLINK_FRAMES - 1);
    localparam logic [FW-1:0] FRM_OFF   = FW'(BLINK_FRAMES);
    localparam logic [PW-1:0] BLANK_END = PW'(BLANK_CYC);

    logic [PW-1:0]          presc_q, presc_d;
    logic [SW-1:0]          slot_q, slot_d;
    logic [FW-1:0]          frame_q, frame_d;
    logic [4*DIGITS-1:0]    pend_data_q, pend_data_d, act_data_q, act_data_d;
    logic [DIGITS-1:0]      pend_dp_q, pend_dp_d, act_dp_q, act_dp_d;
    logic [DIGITS-1:0]      pend_blink_q, pend_blink_d, act_blink_q, act_blink_d;
    logic                   pend_lz_q, pend_lz_d, act_lz_q, act_lz_d;
    logic [DIGITS-1:0]      seg_ctrl_q, seg_ctrl_d;
    logic [7:0]             seg_disp_q, seg_disp_d;
    logic                   frame_done_q, frame_done_d;

    logic                   boundary;
    logic [3:0]             code;
    logic                   dp_bit;
    logic                   blink_bit;
    logic                   nz_above;
    logic                   suppress;
    logic                   blink_off;
    logic                   en;
    logic [6:0]             seg7;

    // Scan counters: prescaler wraps into slot, slot wraps into frame
    always_comb begin
        boundary = (presc_q == PRE_LAST) && (slot_q == SLOT_LAST);
        presc_d  = presc_q + 1'b1;
        slot_d   = slot_q;
        frame_d  = frame_q;
        if (presc_q == PRE_LAST) begin
            presc_d = '0;
            slot_d  = (slot_q == SLOT_LAST) ? '0 : slot_q + 1'b1;
        end
        if (boundary) begin
            frame_d = (frame_q == FRM_LAST) ? '0 : frame_q + 1'b1;
        end
    end

    // Shadow registers: loads go to pending, active only swaps at frame boundary
    always_comb begin
        pend_data_d  = pend_data_q;
        pend_dp_d    = pend_dp_q;
        pend_blink_d = pend_blink_q;
        pend_lz_d    = pend_lz_q;
        act_data_d   = act_data_q;
        act_dp_d     = act_dp_q;
        act_blink_d  = act_blink_q;
        act_lz_d     = act_lz_q;
        if (i_load) begin
            pend_data_d  = i_data;
            pend_dp_d    = i_dp;
            pend_blink_d = i_blink;
            pend_lz_d    = i_lz_en;
        end
        if (boundary) begin
            act_data_d  = pend_data_d;
            act_dp_d    = pend_dp_d;
            act_blink_d = pend_blink_d;
            act_lz_d    = pend_lz_d;
        end
    end

    // Per-slot decode, zero suppression, blink gating and brightness PWM
    always_comb begin
        code      = 4'h0;
        dp_bit    = 1'b0;
        blink_bit = 1'b0;
        nz_above  = 1'b0;
        for (int k = 0; k < DIGITS; k++) begin
            if (SW'(k) == slot_q) begin
                code      = act_data_q[4*k +: 4];
                dp_bit    = act_dp_q[k];
                blink_bit = act_blink_q[k];
            end
            if ((SW'(k) > slot_q) && (act_data_q[4*k +: 4] != 4'h0)) begin
                nz_above = 1'b1;
            end
        end
        suppress = act_lz_q && (slot_q != '0) && (code == 4'h0) && !nz_above;

        case (code)
            4'h0:    seg7 = 7'h40;
            4'h1:    seg7 = 7'h79;
            4'h2:    seg7 = 7'h24;
            4'h3:    seg7 = 7'h30;
            4'h4:    seg7 = 7'h19;
            4'h5:    seg7 = 7'h12;
            4'h6:    seg7 = 7'h02;
            4'h7:    seg7 = 7'h78;
            4'h8:    seg7 = 7'h00;
            4'h9:    seg7 = 7'h10;
            4'hA:    seg7 = 7'h3F;
            default: seg7 = 7'h7F;
        endcase

        blink_off = (frame_q >= FRM_OFF);
        en = (presc_q >= BLANK_END) && (presc_q[3:0] <= i_bright) && !(blink_bit && blink_off);

        seg_disp_d = suppress ? 8'hFF : {~dp_bit, seg7};
        for (int k = 0; k < DIGITS; k++) begin
            seg_ctrl_d[k] = !((SW'(k) == slot_q) && en);
        end
        frame_done_d = boundary;
    end

    // State and registered outputs
    always_ff @(posedge i_clk or negedge r_rst_n) begin
        if (!r_rst_n) begin
            presc_q      <= '0;
            slot_q       <= '0;
            frame_q      <= '0;
            pend_data_q  <= '0;
            pend_dp_q    <= '0;
            pend_blink_q <= '0;
            pend_lz_q    <= 1'b0;
            act_data_q   <= '0;
            act_dp_q     <= '0;
            act_blink_q  <= '0;
            act_lz_q     <= 1'b0;
            seg_ctrl_q   <= '1;
            seg_disp_q   <= 8'hFF;
            frame_done_q <= 1'b0;
        end else begin
            presc_q      <= presc_d;
            slot_q       <= slot_d;
            frame_q      <= frame_d;
            pend_data_q  <= pend_data_d;
            pend_dp_q    <= pend_dp_d;
            pend_blink_q <= pend_blink_d;
            pend_lz_q    <= pend_lz_d;
            act_data_q   <= act_data_d;
            act_dp_q     <= act_dp_d;
            act_blink_q  <= act_blink_d;
            act_lz_q     <= act_lz_d;
            seg_ctrl_q   <= seg_ctrl_d;
            seg_disp_q   <= seg_disp_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign o_seg_control = seg_ctrl_q;
    assign o_seg_display = seg_disp_q;
    assign o_frame_done  = frame_done_q;

endmodule
